parity_stream_checker: RTL and testbench

PARITY_STREAM_CHECKER -- requirements
Module: parity_stream_checker

---
 rtl/parity_stream_checker.sv | 80 ++++++++
 tb/tb_parity_stream_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_checker.sv
// Streaming parity generator/checker: folds multi-beat frames into one parity bit,
// optionally compares it against a received bit and counts failures (saturating).
module parity_stream_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              odd_sel,
    input  logic              chk_en,
    input  logic              chk_par,
    input  logic              clr_cnt,
    output logic              busy,
    output logic              out_valid,
    output logic              out_parity,
    output logic              par_err,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t state;
    logic   acc;
    logic   mode;

    logic beat_par;
    logic frame_x;
    logic frame_mode;
    logic frame_par;
    logic frame_err;

    // In IDLE the current beat opens the frame, so acc/mode are bypassed.
    always_comb begin
        beat_par   = ^in_data;
        frame_x    = (state == ACCUM) ? (acc ^ beat_par) : beat_par;
        frame_mode = (state == ACCUM) ? mode : odd_sel;
        frame_par  = frame_x ^ frame_mode;
        frame_err  = chk_en & (chk_par != frame_par);
    end

    assign busy = (state == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= 1'b0;
            mode       <= 1'b0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            par_err    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (in_last) begin
                    state      <= IDLE;
                    out_valid  <= 1'b1;
                    out_parity <= frame_par;
                    par_err    <= frame_err;
                end else begin
                    state <= ACCUM;
                    acc   <= frame_x;
                    mode  <= frame_mode;
                end
            end
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (in_valid && in_last && frame_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed bench for parity_stream_checker (DATA_W=8, CNT_W=2) with hand-computed expectations.
module tb_parity_stream_checker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       odd_sel;
    logic       chk_en;
    logic       chk_par;
    logic       clr_cnt;
    logic       busy;
    logic       out_valid;
    logic       out_parity;
    logic       par_err;
    logic [1:0] err_cnt;

    int unsigned total;
    int unsigned bad;

    parity_stream_checker #(
        .DATA_W(8),
        .CNT_W (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .odd_sel   (odd_sel),
        .chk_en    (chk_en),
        .chk_par   (chk_par),
        .clr_cnt   (clr_cnt),
        .busy      (busy),
        .out_valid (out_valid),
        .out_parity(out_parity),
        .par_err   (par_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled 1ns after the next edge.
    task automatic drive(input logic [7:0] d, input logic l, input logic o,
                         input logic ce, input logic cp, input logic clr);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        odd_sel  = o;
        chk_en   = ce;
        chk_par  = cp;
        clr_cnt  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        chk_en   = 1'b0;
        chk_par  = 1'b0;
        clr_cnt  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        odd_sel  = 1'b0;
        chk_en   = 1'b0;
        chk_par  = 1'b0;
        clr_cnt  = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_parity", 32'(out_parity), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycle();

        // Single-beat even frame A5 (four ones) -> parity 0, never busy
        drive(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_parity", 32'(out_parity), 32'd0);
        check("single_busy", 32'(busy), 32'd0);
        idle_cycle();
        check("single_pulse_end", 32'(out_valid), 32'd0);

        // Odd frame 01,03,07: X=1^0^1=0, mode locked to 1 -> parity 1
        drive(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("multi_busy", 32'(busy), 32'd1);
        check("multi_no_valid", 32'(out_valid), 32'd0);
        drive(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        idle_cycle();
        check("multi_gap_busy", 32'(busy), 32'd1);
        check("multi_gap_no_valid", 32'(out_valid), 32'd0);
        drive(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("multi_valid", 32'(out_valid), 32'd1);
        check("multi_parity", 32'(out_parity), 32'd1);
        check("multi_busy_end", 32'(busy), 32'd0);
        idle_cycle();
        check("multi_hold_parity", 32'(out_parity), 32'd1);
        check("multi_hold_valid", 32'(out_valid), 32'd0);

        // Check: A5 even parity 0, received 1 -> error
        drive(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("chk_fail_err", 32'(par_err), 32'd1);
        check("chk_fail_cnt", 32'(err_cnt), 32'd1);
        idle_cycle();
        check("chk_hold_err", 32'(par_err), 32'd1);
        drive(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("chk_pass_err", 32'(par_err), 32'd0);
        check("chk_pass_cnt", 32'(err_cnt), 32'd1);
        drive(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("chk_dis_err", 32'(par_err), 32'd0);
        check("chk_dis_cnt", 32'(err_cnt), 32'd1);

        // Five more failures from 1 saturate the 2-bit counter at 3
        for (int i = 0; i < 5; i++) begin
            drive(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            check("sat_err", 32'(par_err), 32'd1);
            check("sat_cnt", 32'(err_cnt), (i < 2) ? 32'(i + 2) : 32'd3);
        end
        idle_cycle();
        check("sat_hold_cnt", 32'(err_cnt), 32'd3);
        drive(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_wins_cnt", 32'(err_cnt), 32'd0);
        check("clr_wins_err", 32'(par_err), 32'd1);
        drive(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("after_clr_cnt", 32'(err_cnt), 32'd1);
        idle_cycle();
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_alone_cnt", 32'(err_cnt), 32'd0);

        // Reset mid-frame discards FF,01 partial frame
        drive(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_parity", 32'(out_parity), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycle();
        check("post_rst_no_valid", 32'(out_valid), 32'd0);
        drive(8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_parity", 32'(out_parity), 32'd1);
        idle_cycle();

        // Back-to-back single-beat frames 03 then 07
        drive(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_valid0", 32'(out_valid), 32'd1);
        check("b2b_parity0", 32'(out_parity), 32'd0);
        drive(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_valid1", 32'(out_valid), 32'd1);
        check("b2b_parity1", 32'(out_parity), 32'd1);
        idle_cycle();
        check("b2b_end", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
